// File: rtl/ame_div_compute.sv
// ame_div_compute: fixed-latency signed divider for the AME pipeline.
// Captures {N, D}, takes magnitudes, runs a radix-2 restoring divide for
// COMP_DATA_BITS cycles, then applies sign, optional rounding and saturation.
// Optional feature: define AME_DIV_ROUND_EN to round half away from zero;
// without it the quotient truncates toward zero. Latency is the same either way.
module ame_div_compute #(
  parameter int COMP_DATA_BITS = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           comp_init_i,
  input  logic [1:0][COMP_DATA_BITS-1:0] comp_data_i,
  output logic                           comp_busy_o,
  output logic                           comp_done_o,
  output logic                           comp_zero_o,
  output logic [COMP_DATA_BITS-1:0]      comp_data_o
);

  localparam int W     = COMP_DATA_BITS;
  localparam int CNT_W = $clog2(W);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(W - 1);
  // Largest magnitudes representable for a positive / negative result.
  localparam logic [W:0]       MAG_MAX_POS = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]       MAG_MAX_NEG = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0]     RES_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     RES_MIN     = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_POST = 2'd3
  } state_t;

  state_t               state_reg;
  logic [1:0][W-1:0]    op_cap_reg;   // [1] = N, [0] = D as captured
  logic                 sign_reg;
  logic [W:0]           n_abs_reg;    // |N|, becomes the quotient as DIV shifts
  logic [W:0]           d_abs_reg;    // |D|
  logic                 d_zero_reg;
  logic                 ovf_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [W:0]           rem_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 zero_reg;
  logic [W-1:0]         data_reg;

  // Per-operand sign and magnitude of the captured values (W+1 bits so the
  // most negative input maps to an exact positive magnitude).
  logic                 op_neg [2];
  logic [W:0]           op_abs [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_abs
    assign op_neg[gi] = op_cap_reg[gi][W-1];
    assign op_abs[gi] = op_neg[gi] ? ((W+1)'(0) - {1'b1, op_cap_reg[gi]})
                                   : {1'b0, op_cap_reg[gi]};
  end

  logic prep_d_zero_next;
  logic prep_ovf_next;

  assign prep_d_zero_next = (op_cap_reg[0] == '0);
  assign prep_ovf_next    = (op_cap_reg[1] == RES_MIN) && (op_cap_reg[0] == '1);

  // One restoring-division step: bring down the next dividend bit and try
  // to subtract the divisor.
  logic [W+1:0] div_trial_next;
  logic         div_ge_next;
  logic [W:0]   div_sub_next;
  logic [W:0]   div_rem_next;

  always_comb begin
    div_trial_next = {rem_reg, n_abs_reg[W-1]};
    div_ge_next    = (div_trial_next >= {1'b0, d_abs_reg});
    // When the subtraction is taken the true difference is below |D|, so
    // the low W+1 bits hold it exactly.
    div_sub_next   = div_trial_next[W:0] - d_abs_reg;
    div_rem_next   = div_ge_next ? div_sub_next : div_trial_next[W:0];
  end

  // Final magnitude (optionally rounded), then sign and saturation.
  logic [W:0]   post_mag_next;
  logic [W-1:0] post_result_next;

  always_comb begin
`ifdef AME_DIV_ROUND_EN
    // Round half away from zero: bump the magnitude when 2*rem >= |D|.
    post_mag_next = n_abs_reg +
                    (W+1)'(({rem_reg, 1'b0} >= {1'b0, d_abs_reg}) ? 1 : 0);
`else
    post_mag_next = n_abs_reg;
`endif
    post_result_next = '0;
    if (d_zero_reg) begin
      post_result_next = '0;
    end else if (ovf_reg) begin
      post_result_next = RES_MAX;
    end else if (sign_reg) begin
      if (post_mag_next > MAG_MAX_NEG) begin
        post_result_next = RES_MIN;
      end else begin
        post_result_next = W'(0) - post_mag_next[W-1:0];
      end
    end else begin
      if (post_mag_next > MAG_MAX_POS) begin
        post_result_next = RES_MAX;
      end else begin
        post_result_next = post_mag_next[W-1:0];
      end
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= S_IDLE;
      op_cap_reg <= '0;
      sign_reg   <= 1'b0;
      n_abs_reg  <= '0;
      d_abs_reg  <= '0;
      d_zero_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      data_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (comp_init_i) begin
            op_cap_reg <= comp_data_i;
            busy_reg   <= 1'b1;
            state_reg  <= S_PREP;
          end
        end
        S_PREP: begin
          sign_reg   <= op_neg[1] ^ op_neg[0];
          n_abs_reg  <= op_abs[1];
          d_abs_reg  <= op_abs[0];
          d_zero_reg <= prep_d_zero_next;
          ovf_reg    <= prep_ovf_next;
          cnt_reg    <= '0;
          rem_reg    <= '0;
          state_reg  <= S_DIV;
        end
        S_DIV: begin
          // Dividend bits leave at the top, quotient bits enter at the bottom.
          n_abs_reg <= {1'b0, n_abs_reg[W-2:0], div_ge_next};
          rem_reg   <= div_rem_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_POST;
          end
        end
        S_POST: begin
          data_reg  <= post_result_next;
          zero_reg  <= d_zero_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign comp_busy_o = busy_reg;
  assign comp_done_o = done_reg;
  assign comp_zero_o = zero_reg;
  assign comp_data_o = data_reg;

endmodule

// File: doc/ame_div_compute.md
AME_DIV_COMPUTE -- requirements
Module: ame_div_compute

Interface
REQ-001 SHALL have parameter COMP_DATA_BITS, default 64, giving the width of each operand and of the result; legal values are 8..64.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port comp_init_i, input, 1, start strobe; sampled only in IDLE.
REQ-005 SHALL have port comp_data_i, input, [1:0][COMP_DATA_BITS], two signed two's-complement operands {N, D}: [1] is numerator N (the M*D-L*C product of the preceding stage), [0] is denominator D.
REQ-006 SHALL have port comp_busy_o, output, 1, high in every state except IDLE.
REQ-007 SHALL have port comp_done_o, output, 1, one-cycle pulse marking a valid result.
REQ-008 SHALL have port comp_zero_o, output, 1, set when the last result came from D == 0.
REQ-009 SHALL have port comp_data_o, output, COMP_DATA_BITS, signed quotient N/D, registered.

Function
REQ-010 SHALL implement the FSM IDLE -> PREP -> DIV -> POST -> IDLE, where POST returns to IDLE unconditionally.
REQ-011 In IDLE, comp_init_i==1 at a rising edge SHALL capture both operands into internal registers and enter PREP; comp_data_i is don't-care afterwards.
REQ-012 PREP (1 cycle) SHALL register the sign of the quotient (sign N XOR sign D).
REQ-012a PREP SHALL register |N| and |D|, each COMP_DATA_BITS+1 bits wide, so that the most negative value is exact.
REQ-012b PREP SHALL register the flags d_zero (D==0) and ovf (N==min and D==-1).
REQ-013 DIV SHALL run a radix-2 restoring division for exactly COMP_DATA_BITS cycles, producing one quotient bit per cycle MSB first, using an iteration counter.
REQ-014 POST (1 cycle) SHALL apply the sign and the rounding mode (REQ-024/025), then load comp_data_o and comp_zero_o and drive comp_done_o=1 for the following cycle.
REQ-015 Latency SHALL be fixed: comp_done_o is high exactly COMP_DATA_BITS+2 cycles after the cycle in which comp_init_i was sampled, for all operand values including D==0.
REQ-016 D==0 SHALL give comp_data_o=0 and comp_zero_o=1; in every other case comp_zero_o=0.
REQ-017 ovf, or any rounded magnitude above 2^(COMP_DATA_BITS-1)-1, SHALL saturate the result to 2^(COMP_DATA_BITS-1)-1 (positive) or -2^(COMP_DATA_BITS-1) (negative).
REQ-018 comp_init_i asserted while comp_busy_o==1 SHALL be ignored, with no queuing and no effect on the current operation.
REQ-019 comp_init_i asserted in the same cycle as comp_done_o SHALL be accepted, because the FSM is in IDLE in that cycle, giving back-to-back operation.
REQ-020 comp_data_o and comp_zero_o SHALL hold their last values until the next POST.
REQ-021 comp_done_o SHALL never be high for two consecutive cycles.

Reset
REQ-022 rst_n_i low SHALL immediately force the FSM to IDLE and the counter to 0, and set comp_busy_o=0, comp_done_o=0, comp_zero_o=0 and comp_data_o=0, regardless of clock.
REQ-023 A reset asserted mid-operation SHALL discard that operation, with no done pulse after release; the first comp_init_i after release starts a fresh operation.

Configuration
REQ-024 With macro AME_DIV_ROUND_EN defined, POST SHALL round half away from zero, incrementing the magnitude when 2*remainder >= |D|, and then saturate per REQ-017.
REQ-025 Without AME_DIV_ROUND_EN, the quotient SHALL truncate toward zero with no rounding logic present; latency is identical in both builds.

Verification
REQ-026 COMP_DATA_BITS=64: N=100, D=7 -> comp_data_o=14, comp_zero_o=0, done at cycle 66; N=-100, D=7 -> -14 in both builds.
REQ-027 N=11, D=2 -> 5 without the macro, 6 with it; N=-11, D=2 -> -5 without, -6 with.
REQ-028 N=12345, D=0 -> comp_data_o=0, comp_zero_o=1, done at cycle 66; N=0x8000_0000_0000_0000, D=-1 -> 0x7FFF_FFFF_FFFF_FFFF.
REQ-029 Start 100/7, pulse comp_init_i with 9/3 at cycle 10, then issue 9/3 in the done cycle -> one result 14 at cycle 66, next result 3 exactly 66 cycles later, and no extra done pulse.
REQ-030 Start 100/7 and assert rst_n_i low at cycle 30 -> all outputs 0 asynchronously and no done pulse; after release, 20/4 -> 5 with normal latency.
